// File: rtl/uart_tx_sequencer.sv
// Byte FIFO and start/busy handshake sequencer in front of uart_transmitter.
// Define UART_TX_CRLF_EN to insert a CR ahead of any LF not already preceded by CR.
module uart_tx_sequencer #(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         wr_data,
    input  logic                          wr_en,
    input  logic                          clr_overflow,
    input  logic                          tx_busy,
    output logic                          tx_start_strobe,
    output logic [DATA_WIDTH-1:0]         tx_data,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          idle
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0] CHAR_LF = DATA_WIDTH'(8'h0A);
    localparam logic [DATA_WIDTH-1:0] CHAR_CR = DATA_WIDTH'(8'h0D);

    localparam logic [1:0] S_SEQ_IDLE      = 2'd0;
    localparam logic [1:0] S_SEQ_START     = 2'd1;
    localparam logic [1:0] S_SEQ_WAIT_DONE = 2'd2;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  ovf_q, ovf_d;
    logic [1:0]            state_q, state_d;
    logic                  strobe_q, strobe_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;

    logic                  launch_s;
    logic                  pop_s;
    logic                  push_s;
    logic                  send_cr_s;
    logic [DATA_WIDTH-1:0] head_s;
    logic [DATA_WIDTH-1:0] launch_byte_s;

    assign head_s = mem_q[rd_ptr_q];

`ifdef UART_TX_CRLF_EN
    logic [DATA_WIDTH-1:0] last_q, last_d;

    // An LF whose predecessor on the wire was not CR first launches a CR and stays queued.
    assign send_cr_s = (head_s == CHAR_LF) && (last_q != CHAR_CR);
`else
    assign send_cr_s = 1'b0;
`endif

    assign launch_s      = (state_q == S_SEQ_IDLE) && !empty_q && !tx_busy;
    assign pop_s         = launch_s && !send_cr_s;
    assign launch_byte_s = send_cr_s ? CHAR_CR : head_s;
    // A full queue still takes a write when the head leaves in the same cycle.
    assign push_s        = wr_en && (!full_q || pop_s);

    // FIFO pointer, occupancy and status flag next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        if (push_s && !pop_s) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop_s && !push_s) begin
            count_d = count_q - CNT_W'(1);
        end else begin
            count_d = count_q;
        end
        full_d  = (count_d == DEPTH_C);
        empty_d = (count_d == CNT_W'(0));
    end

    // Sticky overflow; a new drop outranks a clear in the same cycle.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_en && full_q && !pop_s) begin
            ovf_d = 1'b1;
        end else if (clr_overflow) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Sequencer: launch a byte, hold strobe until busy is seen, then wait for busy to clear.
    always_comb begin
        state_d   = state_q;
        strobe_d  = strobe_q;
        tx_data_d = tx_data_q;
        case (state_q)
            S_SEQ_IDLE: begin
                if (launch_s) begin
                    tx_data_d = launch_byte_s;
                    strobe_d  = 1'b1;
                    state_d   = S_SEQ_START;
                end else begin
                    strobe_d  = 1'b0;
                    state_d   = S_SEQ_IDLE;
                end
            end
            S_SEQ_START: begin
                if (tx_busy) begin
                    strobe_d = 1'b0;
                    state_d  = S_SEQ_WAIT_DONE;
                end else begin
                    strobe_d = 1'b1;
                    state_d  = S_SEQ_START;
                end
            end
            S_SEQ_WAIT_DONE: begin
                strobe_d = 1'b0;
                if (!tx_busy) begin
                    state_d = S_SEQ_IDLE;
                end else begin
                    state_d = S_SEQ_WAIT_DONE;
                end
            end
            default: begin
                strobe_d = 1'b0;
                state_d  = S_SEQ_IDLE;
            end
        endcase
    end

`ifdef UART_TX_CRLF_EN
    // Remember the byte most recently launched so CR-then-LF pairs are not doubled.
    always_comb begin
        last_d = last_q;
        if (launch_s) begin
            last_d = launch_byte_s;
        end else begin
            last_d = last_q;
        end
    end

    // Last-launched byte register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= {DATA_WIDTH{1'b0}};
        end else begin
            last_q <= last_d;
        end
    end
`endif

    // Queue storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= {PTR_W{1'b0}};
            rd_ptr_q  <= {PTR_W{1'b0}};
            count_q   <= {CNT_W{1'b0}};
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            ovf_q     <= 1'b0;
            state_q   <= S_SEQ_IDLE;
            strobe_q  <= 1'b0;
            tx_data_q <= {DATA_WIDTH{1'b0}};
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            strobe_q  <= strobe_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign tx_start_strobe = strobe_q;
    assign tx_data         = tx_data_q;
    assign fifo_full       = full_q;
    assign fifo_empty      = empty_q;
    assign fifo_count      = count_q;
    assign overflow        = ovf_q;
    assign idle            = empty_q && (state_q == S_SEQ_IDLE) && !tx_busy;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// Scoreboard bench for uart_tx_sequencer: an expected-byte stream built from writes,
// checked by a transmitter model that consumes every start strobe.
module tb_uart_tx_sequencer;

    localparam int DEPTH = 8;
    localparam int DW    = 8;
    localparam int FRAME = 12;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [DW-1:0] wr_data = 8'h00;
    logic          wr_en = 1'b0;
    logic          clr_overflow = 1'b0;
    logic          tx_busy;
    logic          tx_start_strobe;
    logic [DW-1:0] tx_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic [3:0]    fifo_count;
    logic          overflow;
    logic          idle;

    logic          hold_busy = 1'b0;
    logic          xbusy = 1'b0;
    int            xcnt = 0;
    logic [DW-1:0] cap = 8'h00;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_exp = 8'h00;
    int            tests = 0;
    int            fails = 0;

    assign tx_busy = hold_busy | xbusy;

    uart_tx_sequencer #(.FIFO_DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk            (clk),
        .reset          (reset),
        .wr_data        (wr_data),
        .wr_en          (wr_en),
        .clr_overflow   (clr_overflow),
        .tx_busy        (tx_busy),
        .tx_start_strobe(tx_start_strobe),
        .tx_data        (tx_data),
        .fifo_full      (fifo_full),
        .fifo_empty     (fifo_empty),
        .fifo_count     (fifo_count),
        .overflow       (overflow),
        .idle           (idle)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // What the line should carry for an accepted byte, CR insertion included when enabled.
    task automatic model_write(input logic [DW-1:0] b);
`ifdef UART_TX_CRLF_EN
        if (b == 8'h0A && last_exp != 8'h0D) exp_q.push_back(8'h0D);
`endif
        exp_q.push_back(b);
        last_exp = b;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic write_byte(input logic [DW-1:0] b, input bit accepted);
        wr_en   = 1'b1;
        wr_data = b;
        if (accepted) model_write(b);
        cycle();
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && xbusy == 1'b0 && idle === 1'b1) && n < 3000) begin
            cycle();
            n++;
        end
        check(name, (n < 3000) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Transmitter model and monitor: takes each strobe as a frame start and scores the byte.
    always @(negedge clk) begin
        if (!reset) begin
            xbusy = 1'b0;
            xcnt  = 0;
        end else if (xbusy) begin
            check("tx_data_stable", tx_data, cap);
            xcnt--;
            if (xcnt == 0) xbusy = 1'b0;
        end else if (tx_start_strobe && !hold_busy) begin
            cap = tx_data;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_byte: got %0h, expected no frame", tx_data);
            end else begin
                check("tx_byte", tx_data, exp_q.pop_front());
            end
            xbusy = 1'b1;
            xcnt  = FRAME;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, expected finish within budget");
        $fatal(1, "timeout");
    end

    initial begin
        int peak;
        logic [DW-1:0] rb;

        repeat (10) @(posedge clk);
        #1;
        check("rst_strobe", tx_start_strobe, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_empty", fifo_empty, 1);
        check("rst_full", fifo_full, 0);
        check("rst_count", fifo_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_idle", idle, 1);
        reset = 1'b1;
        repeat (3) cycle();

        // Single byte: strobe one cycle after the write edge.
        write_byte(8'hAA, 1'b1);
        cycle();
        check("lat_strobe", tx_start_strobe, 1);
        check("lat_data", tx_data, 8'hAA);
        wait_drain("drain_single");
        check("single_idle", idle, 1);
        check("single_strobe_low", tx_start_strobe, 0);

        // Burst of eight: occupancy peaks at seven, nothing dropped.
        peak = 0;
        for (int i = 1; i <= 8; i++) begin
            write_byte(DW'(i), 1'b1);
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        for (int i = 0; i < 4; i++) begin
            cycle();
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        check("burst_peak", peak, 7);
        check("burst_overflow", overflow, 0);
        wait_drain("drain_burst");

        // Transmitter held busy: eight fit, ninth is dropped.
        hold_busy = 1'b1;
        for (int i = 0; i < 9; i++) write_byte(8'h20 + DW'(i), (i < 8));
        check("full_flag", fifo_full, 1);
        check("full_count", fifo_count, 8);
        check("ovf_set", overflow, 1);
        clr_overflow = 1'b1;
        cycle();
        clr_overflow = 1'b0;
        check("ovf_clr", overflow, 0);
        clr_overflow = 1'b1;
        write_byte(8'h77, 1'b0);
        clr_overflow = 1'b0;
        check("ovf_set_wins", overflow, 1);
        check("full_count_after_drop", fifo_count, 8);

        // Full queue with a write coincident with the pop.
        hold_busy = 1'b0;
        write_byte(8'h5A, 1'b1);
        check("pop_write_count", fifo_count, 8);
        check("pop_write_full", fifo_full, 1);
        clr_overflow = 1'b1;
        cycle();
        clr_overflow = 1'b0;
        wait_drain("drain_full");
        check("drain_empty", fifo_empty, 1);

        // LF handling.
        write_byte(8'h41, 1'b1);
        write_byte(8'h0A, 1'b1);
        wait_drain("drain_lf1");
        write_byte(8'h0D, 1'b1);
        write_byte(8'h0A, 1'b1);
        wait_drain("drain_lf2");

        // Randomized traffic, never beyond what the queue can hold.
        for (int c = 0; c < 800; c++) begin
            if (($urandom % 3) == 0 && exp_q.size() < DEPTH) begin
                case ($urandom % 4)
                    0:       rb = 8'h0A;
                    1:       rb = 8'h0D;
                    default: rb = DW'($urandom);
                endcase
                wr_en   = 1'b1;
                wr_data = rb;
                model_write(rb);
            end else begin
                wr_en = 1'b0;
            end
            cycle();
        end
        wr_en = 1'b0;
        wait_drain("drain_random");
        check("random_overflow", overflow, 0);
        check("random_count", fifo_count, 0);

        // Reset mid-frame with bytes still queued.
        for (int i = 0; i < 4; i++) write_byte(8'h61 + DW'(i), 1'b1);
        repeat (3) cycle();
        reset = 1'b0;
        exp_q.delete();
        last_exp = 8'h00;
        #1;
        check("mid_rst_empty", fifo_empty, 1);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_strobe", tx_start_strobe, 0);
        cycle();
        check("mid_rst_strobe_next", tx_start_strobe, 0);
        cycle();
        reset = 1'b1;
        repeat (100) cycle();
        check("post_rst_empty", fifo_empty, 1);
        check("post_rst_idle", idle, 1);
        check("leftover_expected", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
